// File: rtl/sync_fifo_bypass_rr_pkg.sv
// Shared constants and helpers for the multi-channel bypass FIFO with round-robin output.
// Latency: none (package only).
// Backpressure: none (package only).
package sync_fifo_bypass_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 64;

    // Width of an index that can address n items; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_bypass_rr_ch.sv
// One channel: head register plus (DEPTH-1)-entry circular memory, count, full and sticky overflow.
// Latency: a write into an empty channel (or one draining its last word) is at the head one cycle later.
// Backpressure: writes while full are dropped and flagged; pop is only asserted while head_vld is set.
module bypass_fifo_ch
    import sync_fifo_bypass_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             overflow
);

    localparam int MEMD = DEPTH - 1;
    localparam int PW   = chan_w(MEMD);
    localparam int CW   = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [MEMD];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             accept;
    logic             mem_empty;
    logic             head_load_wr;
    logic             head_load_mem;
    logic             mem_wr;

    // Pointers run modulo the memory size, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MEMD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Steer each accepted write either straight into the head or into the memory behind it.
    always_comb begin
        accept        = wr_en && !full;
        // The memory holds every stored word except the one sitting in the head.
        mem_empty     = (cnt == {{(CW-1){1'b0}}, head_vld});
        head_load_mem = pop && !mem_empty;
        head_load_wr  = accept && (!head_vld || (pop && mem_empty));
        mem_wr        = accept && !head_load_wr;
        case ({accept, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // Head register, pointers, occupancy and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_vld <= 1'b0;
            head_dat <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            full <= (cnt_nxt == CW'(DEPTH));
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (head_load_mem) begin
                head_dat <= mem[rd_ptr];
                rd_ptr   <= ptr_inc(rd_ptr);
            end else if (head_load_wr) begin
                head_dat <= wr_data;
                head_vld <= 1'b1;
            end else if (pop) begin
                head_vld <= 1'b0;
            end
            if (mem_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
        end
    end

    // Storage array; contents are only ever read behind a valid pointer so no reset is needed.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/sync_fifo_bypass_rr.sv
// NCH independent bypass FIFOs merged onto one output by a round-robin arbiter.
// Latency: one cycle from write edge to o_Valid/o_Data on an idle channel.
// Backpressure: i_Ready low locks the presented channel/word until it transfers; full channels drop writes.
module sync_fifo_bypass_rr
    import sync_fifo_bypass_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   CLK,
    input  logic                   Reset_n,
    input  logic [NCH-1:0]         i_WrEn,
    input  logic [NCH*WIDTH-1:0]   i_WrData,
    output logic [NCH-1:0]         o_Full,
    output logic [NCH-1:0]         o_Overflow,
    output logic                   o_Valid,
    output logic [WIDTH-1:0]       o_Data,
    output logic [chan_w(NCH)-1:0] o_Chan,
    input  logic                   i_Ready
);

    localparam int CW = chan_w(NCH);

    logic [NCH-1:0]   head_vld;
    logic [NCH-1:0]   pop;
    logic [WIDTH-1:0] head_dat [NCH];
    logic [CW-1:0]    rr_ptr;
    logic [CW-1:0]    lock_ch;
    logic             lock;
    logic [CW-1:0]    pick;
    logic [CW-1:0]    sel;
    logic [CW-1:0]    idx;
    logic             found;
    logic             xfer;
    int               scan;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        bypass_fifo_ch #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (CLK),
            .rst_n    (Reset_n),
            .wr_en    (i_WrEn[c]),
            .wr_data  (i_WrData[c*WIDTH +: WIDTH]),
            .pop      (pop[c]),
            .head_vld (head_vld[c]),
            .head_dat (head_dat[c]),
            .full     (o_Full[c]),
            .overflow (o_Overflow[c])
        );
    end

    // Round-robin search: first valid head at or after rr_ptr, wrapping past NCH-1.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        scan  = 0;
        for (int i = 0; i < NCH; i++) begin
            scan = int'(rr_ptr) + i;
            if (scan >= NCH) begin
                scan = scan - NCH;
            end
            idx = CW'(scan);
            if (!found && head_vld[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Output mux; a stalled word keeps its channel even if higher-priority heads appear.
    always_comb begin
        sel     = lock ? lock_ch : pick;
        o_Valid = |head_vld;
        o_Chan  = sel;
        o_Data  = head_dat[sel];
        xfer    = o_Valid && i_Ready;
        for (int c = 0; c < NCH; c++) begin
            pop[c] = xfer && (sel == CW'(c));
        end
    end

    // Stall lock and round-robin pointer advance.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_ch <= '0;
        end else begin
            lock    <= o_Valid && !i_Ready;
            lock_ch <= sel;
            if (xfer) begin
                rr_ptr <= (sel == CW'(NCH - 1)) ? '0 : sel + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_bypass_rr.sv
// Randomised and directed bench with a queue-based reference model and decoupled scoreboard.
// Latency: inputs change 1ns after the rising edge; outputs are checked on the falling edge.
// Backpressure: i_Ready is driven randomly or per scenario.
module tb_sync_fifo_bypass_rr;

    localparam int NCH   = 4;
    localparam int DEPTH = 8;
    localparam int WIDTH = 64;
    localparam int CW    = 2;

    logic                 CLK = 1'b0;
    logic                 Reset_n;
    logic [NCH-1:0]       i_WrEn;
    logic [NCH*WIDTH-1:0] i_WrData;
    logic [NCH-1:0]       o_Full;
    logic [NCH-1:0]       o_Overflow;
    logic                 o_Valid;
    logic [WIDTH-1:0]     o_Data;
    logic [CW-1:0]        o_Chan;
    logic                 i_Ready;

    int total = 0;
    int bad   = 0;

    // Reference model: one queue of expected words per channel plus arbitration state.
    logic [WIDTH-1:0] mq [NCH][$];
    logic [NCH-1:0]   exp_ovf  = '0;
    logic [NCH-1:0]   pend_pop = '0;
    int               rr_m      = 0;
    bit               lock_m    = 0;
    int               lock_ch_m = 0;
    bit               ev_m;
    int               ec_m;
    int               log_ch[$];
    logic [WIDTH-1:0] log_dat[$];

    sync_fifo_bypass_rr #(
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .i_WrEn     (i_WrEn),
        .i_WrData   (i_WrData),
        .o_Full     (o_Full),
        .o_Overflow (o_Overflow),
        .o_Valid    (o_Valid),
        .o_Data     (o_Data),
        .o_Chan     (o_Chan),
        .i_Ready    (i_Ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int pick_m();
        for (int i = 0; i < NCH; i++) begin
            if (mq[(rr_m + i) % NCH].size() != 0) return (rr_m + i) % NCH;
        end
        return 0;
    endfunction

    // Stimulus side: every write applied at an edge is accepted into the model or counted as dropped.
    always @(posedge CLK) begin
        if (Reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                if (i_WrEn[c]) begin
                    if (int'(mq[c].size()) + int'(pend_pop[c]) < DEPTH)
                        mq[c].push_back(i_WrData[c*WIDTH +: WIDTH]);
                    else
                        exp_ovf[c] = 1'b1;
                end
            end
            pend_pop = '0;
        end
    end

    // Monitor: compare presented outputs with the model, then retire the word if it transfers.
    always @(negedge CLK) begin
        if (!Reset_n) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            exp_ovf   = '0;
            pend_pop  = '0;
            rr_m      = 0;
            lock_m    = 0;
            lock_ch_m = 0;
        end else begin
            ev_m = 0;
            for (int c = 0; c < NCH; c++) if (mq[c].size() != 0) ev_m = 1;
            chk("valid", o_Valid, ev_m);
            for (int c = 0; c < NCH; c++) begin
                chk("full", o_Full[c], mq[c].size() == DEPTH);
                chk("overflow", o_Overflow[c], exp_ovf[c]);
            end
            if (ev_m) begin
                ec_m = lock_m ? lock_ch_m : pick_m();
                chk("chan", o_Chan, ec_m);
                chk("data", o_Data, mq[ec_m][0]);
                if (i_Ready) begin
                    log_ch.push_back(ec_m);
                    log_dat.push_back(mq[ec_m].pop_front());
                    pend_pop[ec_m] = 1'b1;
                    rr_m   = (ec_m + 1) % NCH;
                    lock_m = 0;
                end else begin
                    lock_m    = 1;
                    lock_ch_m = ec_m;
                end
            end else begin
                lock_m = 0;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr1(input int c, input logic [WIDTH-1:0] d);
        i_WrEn = '0;
        i_WrEn[c] = 1'b1;
        i_WrData[c*WIDTH +: WIDTH] = d;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        i_WrEn  = '0;
        i_Ready = 1'b0;
        #1;
        chk("rst_valid", o_Valid, 0);
        chk("rst_full", o_Full, 0);
        chk("rst_overflow", o_Overflow, 0);
        chk("rst_chan", o_Chan, 0);
        chk("rst_data", o_Data, 0);
        step();
        step();
        Reset_n = 1'b1;
        log_ch.delete();
        log_dat.delete();
    endtask

    task automatic drain(input int max_cyc);
        int left;
        i_Ready = 1'b1;
        i_WrEn  = '0;
        for (int n = 0; n < max_cyc; n++) begin
            left = 0;
            for (int c = 0; c < NCH; c++) left += mq[c].size();
            if (left == 0) break;
            step();
        end
        @(negedge CLK);
        chk("drained_valid", o_Valid, 0);
        step();
    endtask

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        Reset_n  = 1'b0;
        i_WrEn   = '0;
        i_WrData = '0;
        i_Ready  = 1'b0;
        step();

        // Single word through an idle channel: one-cycle latency, gone the cycle after.
        do_reset();
        i_Ready = 1'b1;
        wr1(0, 64'hA5);
        step();
        i_WrEn = '0;
        @(negedge CLK);
        chk("lat_valid", o_Valid, 1);
        chk("lat_chan", o_Chan, 0);
        chk("lat_data", o_Data, 64'hA5);
        step();
        @(negedge CLK);
        chk("lat_gone", o_Valid, 0);
        step();

        // One word in every channel drains 0,1,2,3; then ch2 and ch0 drain 0,2.
        do_reset();
        for (int c = 0; c < NCH; c++) i_WrData[c*WIDTH +: WIDTH] = 64'h10 + 64'(c);
        i_WrEn = '1;
        step();
        drain(50);
        chk("rr4_len", log_ch.size(), 4);
        for (int i = 0; i < 4 && i < log_ch.size(); i++) chk("rr4_chan", log_ch[i], i);
        log_ch.delete();
        log_dat.delete();
        i_WrEn = 4'b0101;
        step();
        drain(50);
        chk("rr2_len", log_ch.size(), 2);
        if (log_ch.size() == 2) begin
            chk("rr2_first", log_ch[0], 0);
            chk("rr2_second", log_ch[1], 2);
        end

        // Stall on ch2 while ch0/ch1 arrive: selection holds, then wraps to 0.
        do_reset();
        wr1(2, 64'h222);
        step();
        i_WrEn = '0;
        step();
        i_WrEn = 4'b0011;
        i_WrData[0 +: WIDTH]     = 64'h200;
        i_WrData[WIDTH +: WIDTH] = 64'h211;
        step();
        i_WrEn = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("lock_chan", o_Chan, 2);
            chk("lock_data", o_Data, 64'h222);
            step();
        end
        drain(50);
        chk("lock_len", log_ch.size(), 3);
        if (log_ch.size() == 3) begin
            chk("lock_o0", log_ch[0], 2);
            chk("lock_o1", log_ch[1], 0);
            chk("lock_o2", log_ch[2], 1);
        end

        // Fill ch1 past capacity: full after DEPTH writes, extra write dropped and flagged.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr1(1, 64'h100 + 64'(i));
            step();
            if (i == DEPTH - 1) begin
                @(negedge CLK);
                chk("fill_full", o_Full[1], 1);
                chk("fill_noovf", o_Overflow[1], 0);
            end
        end
        i_WrEn = '0;
        @(negedge CLK);
        chk("fill_ovf", o_Overflow[1], 1);
        step();
        drain(50);
        chk("fill_len", log_dat.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < log_dat.size(); i++) chk("fill_word", log_dat[i], 64'h100 + 64'(i));

        // Ch3 full, then write and pop together across pointer wrap; the write meeting full is dropped.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr1(3, 64'h300 + 64'(i));
            step();
        end
        i_Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr1(3, 64'h400 + 64'(i));
            step();
        end
        i_WrEn = '0;
        chk("wrap_ovf", o_Overflow[3], 1);
        drain(100);
        chk("wrap_len", log_dat.size(), DEPTH + 19);
        for (int i = 0; i < log_dat.size() && i < DEPTH + 19; i++)
            chk("wrap_word", log_dat[i], (i < DEPTH) ? 64'h300 + 64'(i) : 64'h401 + 64'(i - DEPTH));

        // Reset with five words queued: outputs clear at once, fresh write returns in one cycle.
        do_reset();
        i_WrEn = '1;
        step();
        wr1(0, 64'h55);
        step();
        i_WrEn = '0;
        step();
        Reset_n = 1'b0;
        #1;
        chk("mid_valid", o_Valid, 0);
        chk("mid_full", o_Full, 0);
        chk("mid_chan", o_Chan, 0);
        chk("mid_data", o_Data, 0);
        step();
        Reset_n = 1'b1;
        i_Ready = 1'b1;
        wr1(2, 64'h999);
        step();
        i_WrEn = '0;
        @(negedge CLK);
        chk("post_valid", o_Valid, 1);
        chk("post_chan", o_Chan, 2);
        chk("post_data", o_Data, 64'h999);
        step();

        // Random traffic, first with generous then with scarce downstream acceptance.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                i_WrEn[c] = ($urandom_range(0, 9) < 4);
                i_WrData[c*WIDTH +: WIDTH] = {$urandom, $urandom};
            end
            i_Ready = (n < 1500) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            step();
        end
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
